// File: rtl/iomem_arbiter_pkg.sv
// Shared definitions for the two-master iomem arbiter: bus widths, the FSM
// state encoding and the default error read-data pattern.
package iomem_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int CNT_W  = 16;

  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Index of the owner in a one-hot two-bit grant (00 maps to 0).
  function automatic logic onehot_to_idx(input logic [1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/iomem_arbiter_rr_arb2.sv
// Two-requester round-robin selector. The last-grant register remembers who
// was served most recently so a simultaneous request goes to the other one.
module rr_arb2
  import iomem_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       load,
  output logic [1:0] gnt
);

  // 1 = m1 was served last; reset value hands first priority to m0.
  logic last_reg;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_reg ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_reg <= 1'b1;
    end else if (load && (gnt != 2'b00)) begin
      last_reg <= onehot_to_idx(gnt);
    end
  end

endmodule

// File: rtl/iomem_arbiter.sv
// Arbitrates two iomem masters onto one slave port, one transaction at a
// time, with a slave-response timeout that answers the master with ERR_DATA.
module iomem_arbiter
  import iomem_arbiter_pkg::*;
#(
  parameter int                TIMEOUT  = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              m0_valid,
  input  logic [STRB_W-1:0] m0_wstrb,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_valid,
  input  logic [STRB_W-1:0] m1_wstrb,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              s_valid,
  output logic [STRB_W-1:0] s_wstrb,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,

  output logic              timeout_err,
  output logic [1:0]        grant
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [1:0]             req;
  logic [1:0][ADDR_W-1:0] m_addr;
  logic [1:0][DATA_W-1:0] m_wdata;
  logic [1:0][STRB_W-1:0] m_wstrb;
  logic [1:0]             m_ready;
  logic [1:0][DATA_W-1:0] m_rdata;

  assign req     = {m1_valid, m0_valid};
  assign m_addr  = {m1_addr, m0_addr};
  assign m_wdata = {m1_wdata, m0_wdata};
  assign m_wstrb = {m1_wstrb, m0_wstrb};

  state_t           state_reg, state_next;
  logic [1:0]       grant_reg, grant_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;

  logic       busy;
  logic       expired;
  logic       done;
  logic       sel;
  logic       arb_load;
  logic [1:0] arb_gnt;

  rr_arb2 u_rr_arb2 (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .load  (arb_load),
    .gnt   (arb_gnt)
  );

  assign busy    = (state_reg == ST_BUSY);
  assign expired = busy && (cnt_reg == TIMEOUT_CNT);
  // A slave response in the expiry cycle still counts as a normal completion.
  assign done    = busy && (s_ready || expired);
  assign sel     = onehot_to_idx(grant_reg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      grant_reg <= 2'b00;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    arb_load   = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (req != 2'b00) begin
          arb_load   = 1'b1;
          grant_next = arb_gnt;
          cnt_next   = '0;
          state_next = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (s_ready) begin
          grant_next = 2'b00;
          state_next = ST_RELEASE;
        end else if (expired) begin
          err_next   = 1'b1;
          grant_next = 2'b00;
          state_next = ST_RELEASE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      // One dead cycle so a master still lowering valid is not re-granted.
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end

      default: begin
        grant_next = 2'b00;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign s_valid = busy;
  assign s_addr  = busy ? m_addr[sel]  : '0;
  assign s_wdata = busy ? m_wdata[sel] : '0;
  assign s_wstrb = busy ? m_wstrb[sel] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign m_ready[gi] = done && grant_reg[gi];
      assign m_rdata[gi] = m_ready[gi] ? (s_ready ? s_rdata : ERR_DATA) : '0;
    end
  endgenerate

  assign m0_ready    = m_ready[0];
  assign m1_ready    = m_ready[1];
  assign m0_rdata    = m_rdata[0];
  assign m1_rdata    = m_rdata[1];
  assign grant       = grant_reg;
  assign timeout_err = err_reg;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Randomized self-checking bench for iomem_arbiter; a transaction-level model
// predicts winner, completion cycle, returned data and the sticky error flag.
module tb_iomem_arbiter;

  localparam int          TO      = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset;
  logic        mv [2];
  logic [3:0]  mw [2];
  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic        timeout_err;
  logic [1:0]  grant;

  // reference model state
  bit          pend [2];
  int          last;
  bit          err_exp;
  bit          fix_en;
  logic [31:0] fix_rdata;
  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_round = 0;

  iomem_arbiter #(.TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .m0_valid    (mv[0]),
    .m0_wstrb    (mw[0]),
    .m0_addr     (ma[0]),
    .m0_wdata    (md[0]),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m1_valid    (mv[1]),
    .m1_wstrb    (mw[1]),
    .m1_addr     (ma[1]),
    .m1_wdata    (md[1]),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_wstrb     (s_wstrb),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .timeout_err (timeout_err),
    .grant       (grant)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rdy(input int m);
    return (m == 0) ? m0_ready : m1_ready;
  endfunction

  function automatic logic [31:0] rdt(input int m);
    return (m == 0) ? m0_rdata : m1_rdata;
  endfunction

  task automatic set_req(input int m, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wdata);
    mv[m] = 1'b1;
    ma[m] = addr;
    mw[m] = strb;
    md[m] = wdata;
    pend[m] = 1'b1;
  endtask

  // Called at posedge+1 of an IDLE cycle with requests already driven;
  // returns at posedge+1 of the next IDLE cycle.
  task automatic run_round(input int lat, input bit drop);
    int          w, l, kdone;
    bit          to;
    logic [31:0] rd_exp;
    if (!pend[0] && !pend[1]) return;
    w     = (pend[0] && pend[1]) ? (last == 1 ? 0 : 1) : (pend[0] ? 0 : 1);
    l     = 1 - w;
    to    = (lat > TO);
    kdone = to ? TO : lat;
    rd_exp = '0;

    s_ready = 1'($urandom);
    s_rdata = $urandom;
    @(negedge clock);
    check_val("idle_svalid", 32'(s_valid), 0);
    check_val("idle_grant", 32'(grant), 0);
    check_val("idle_ready", 32'({m1_ready, m0_ready}), 0);

    for (int k = 0; k <= kdone; k++) begin
      @(posedge clock); #1;
      s_ready = (k == lat);
      s_rdata = fix_en ? fix_rdata : $urandom;
      if (drop && k == 1) mv[w] = 1'b0;
      @(negedge clock);
      rd_exp = to ? ERR_VAL : s_rdata;
      check_val("busy_svalid", 32'(s_valid), 1);
      check_val("busy_grant", 32'(grant), 32'(1 << w));
      check_val("busy_saddr", s_addr, ma[w]);
      check_val("busy_swstrb", 32'(s_wstrb), 32'(mw[w]));
      check_val("busy_swdata", s_wdata, md[w]);
      check_val("win_ready", 32'(rdy(w)), 32'(k == kdone));
      check_val("win_rdata", rdt(w), (k == kdone) ? rd_exp : 32'h0);
      check_val("lose_ready", 32'(rdy(l)), 0);
      check_val("lose_rdata", rdt(l), 0);
      check_val("busy_err", 32'(timeout_err), 32'(err_exp));
    end

    last    = w;
    pend[w] = 1'b0;
    if (to) err_exp = 1'b1;
    n_round++;
    $display("round %0d: m%0d addr=%h wstrb=%h lat=%0d timeout=%0d rdata=%h",
             n_round, w, ma[w], mw[w], lat, to, rd_exp);

    @(posedge clock); #1;
    mv[w]   = 1'b0;
    s_ready = 1'($urandom);
    @(negedge clock);
    check_val("rel_svalid", 32'(s_valid), 0);
    check_val("rel_grant", 32'(grant), 0);
    check_val("rel_ready", 32'({m1_ready, m0_ready}), 0);
    check_val("rel_err", 32'(timeout_err), 32'(err_exp));
    @(posedge clock); #1;
    s_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; mw[m] = '0; ma[m] = '0; md[m] = '0; pend[m] = 1'b0;
    end
    s_ready = 1'b0; s_rdata = '0;
    last = 1; err_exp = 1'b0; fix_en = 1'b0; fix_rdata = '0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("rst_svalid", 32'(s_valid), 0);
    check_val("rst_grant", 32'(grant), 0);
    check_val("rst_ready", 32'({m1_ready, m0_ready}), 0);
    check_val("rst_err", 32'(timeout_err), 0);
    check_val("rst_saddr", s_addr, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    // both masters keep requesting: expect m0, m1, m0 then drain m1
    set_req(0, $urandom, 4'($urandom), $urandom);
    set_req(1, $urandom, 4'($urandom), $urandom);
    run_round(1, 0);
    set_req(0, $urandom, 4'($urandom), $urandom);
    run_round(0, 0);
    set_req(1, $urandom, 4'($urandom), $urandom);
    run_round(3, 0);
    run_round(2, 0);

    // single m0 read, slave answers after two cycles with 3
    set_req(0, 32'h0300_0000, 4'h0, $urandom);
    fix_en = 1'b1; fix_rdata = 32'h0000_0003;
    run_round(2, 0);
    fix_en = 1'b0;

    // spurious s_ready with no requests
    for (int i = 0; i < 3; i++) begin
      s_ready = 1'b1;
      @(negedge clock);
      check_val("spur_ready", 32'({m1_ready, m0_ready}), 0);
      check_val("spur_grant", 32'(grant), 0);
      check_val("spur_svalid", 32'(s_valid), 0);
      @(posedge clock); #1;
    end
    s_ready = 1'b0;

    // response on the exact expiry cycle is a normal completion
    set_req(0, $urandom, 4'($urandom), $urandom);
    run_round(TO, 0);
    check_val("edge_no_err", 32'(timeout_err), 0);

    // m1 write to a silent slave times out; flag stays set afterwards
    set_req(1, 32'h0500_0010, 4'hF, 32'h1234_5678);
    run_round(TO + 5, 0);
    set_req(0, $urandom, 4'($urandom), $urandom);
    run_round(1, 0);
    check_val("err_sticky", 32'(timeout_err), 1);

    // reset during BUSY of an m0 transaction, then m0 must win again
    set_req(0, $urandom, 4'($urandom), $urandom);
    @(negedge clock);
    @(posedge clock); #1;
    s_ready = 1'b0;
    @(negedge clock);
    check_val("pre_rst_svalid", 32'(s_valid), 1);
    @(posedge clock); #1;
    reset   = 1'b1;
    s_ready = 1'b1;
    #1;
    check_val("arst_svalid", 32'(s_valid), 0);
    check_val("arst_grant", 32'(grant), 0);
    check_val("arst_ready", 32'({m1_ready, m0_ready}), 0);
    check_val("arst_rdata", m0_rdata, 0);
    check_val("arst_saddr", s_addr, 0);
    check_val("arst_swdata", s_wdata, 0);
    check_val("arst_swstrb", 32'(s_wstrb), 0);
    check_val("arst_err", 32'(timeout_err), 0);
    @(negedge clock);
    check_val("arst_ready2", 32'({m1_ready, m0_ready}), 0);
    @(posedge clock); #1;
    reset   = 1'b0;
    s_ready = 1'b0;
    last    = 1;
    err_exp = 1'b0;
    set_req(1, $urandom, 4'($urandom), $urandom);
    run_round(2, 0);
    run_round(1, 0);

    // randomized rounds, including dropped valids and timeouts
    for (int r = 0; r < 40; r++) begin
      for (int m = 0; m < 2; m++)
        if (!pend[m] && ($urandom_range(0, 1) == 1))
          set_req(m, $urandom, 4'($urandom), $urandom);
      if (!pend[0] && !pend[1])
        set_req($urandom_range(0, 1), $urandom, 4'($urandom), $urandom);
      run_round($urandom_range(0, TO + 3), ($urandom_range(0, 3) == 0));
    end
    if (pend[0] || pend[1]) run_round(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/iomem_arbiter.md
IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, slave-response cycles allowed before the arbiter aborts a grant (legal range 1..65535).
REQ-002 Parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned on a timed-out access.
REQ-003 clock  in  1  single clock for all logic.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 m0_valid, m1_valid  in  1  master requests; held until that master's ready pulse.
REQ-006 m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 = read.
REQ-007 m0_addr, m1_addr, m0_wdata, m1_wdata  in  32  address / write data.
REQ-008 m0_ready, m1_ready  out  1  one-cycle completion pulse to the granted master.
REQ-009 m0_rdata, m1_rdata  out  32  read data, valid while the matching ready is high.
REQ-010 s_valid, s_wstrb[4], s_addr[32], s_wdata[32]  out  shared iomem slave request.
REQ-011 s_ready  in  1, s_rdata  in  32  slave completion and read data.
REQ-012 timeout_err  out  1  sticky flag, set on any timeout.
REQ-013 grant  out  2  one-hot current owner (00 = none).

Function
REQ-014 States: IDLE, BUSY, RELEASE.
REQ-015 IDLE: requests sampled; winner registered into grant; next state BUSY; s_valid rises the cycle after the request is seen (one-cycle grant latency).
REQ-016 Arbitration: round-robin; only one requester -> it wins; both -> the master not served last wins; after reset m0 holds priority.
REQ-017 BUSY: s_valid=1; s_addr/s_wstrb/s_wdata driven from the granted master combinationally; non-granted master's ready stays 0.
REQ-018 BUSY and s_ready=1: granted mX_ready=1 same cycle, mX_rdata=s_rdata; next state RELEASE.
REQ-019 RELEASE: exactly one cycle, s_valid=0, grant=00, no ready; prevents re-sampling a master still dropping valid; then IDLE.
REQ-020 Timeout counter (16-bit) cleared on entering BUSY, increments each BUSY cycle without s_ready.
REQ-021 Counter reaches TIMEOUT with s_ready=0: granted mX_ready=1, mX_rdata=ERR_DATA, timeout_err set, s_valid dropped next cycle, next state RELEASE.
REQ-022 s_ready in the same cycle the counter reaches TIMEOUT: normal completion wins; timeout_err unchanged.
REQ-023 Granted master drops valid in BUSY (protocol violation): no abort; transaction completes normally.
REQ-024 s_ready outside BUSY: ignored.
REQ-025 mX_rdata = 0 whenever mX_ready=0.
REQ-026 Full-duplex overlap forbidden: at most one s_valid transaction outstanding.

Reset
REQ-027 On reset assertion, asynchronously: state=IDLE, grant=00, s_valid=0, s_wstrb=0, s_addr=0, s_wdata=0, m0_ready=m1_ready=0, rdata=0, counter=0, timeout_err=0, priority to m0.
REQ-028 Reset mid-BUSY abandons the transaction; no ready pulse generated; slave sees s_valid fall immediately.
REQ-029 timeout_err clears only on reset.

Structure
REQ-030 Shared package holds the state enumeration, ERR_DATA default and IOMEM width constants (ADDR_W=32, DATA_W=32, STRB_W=4).
REQ-031 One sub-module, rr_arb2: 2-requester round-robin selector with last-grant register; all else in iomem_arbiter.

Verification
REQ-032 m0 read 0x0300_0000, slave ready after 2 cycles with 0x0000_0003 -> s_valid one cycle after m0_valid, m0_ready one cycle, m0_rdata=0x0000_0003, m1_ready=0.
REQ-033 m0 and m1 assert valid same cycle, three back-to-back rounds -> grant order m0, m1, m0; RELEASE cycle between each.
REQ-034 m1 write 0x0500_0010, wstrb=4'hF, wdata=0x1234_5678, slave never ready, TIMEOUT=8 -> m1_ready after 8 BUSY cycles, m1_rdata=0xDEAD_BEEF, timeout_err=1 and stays 1.
REQ-035 s_ready on exact timeout cycle -> slave data returned, timeout_err=0.
REQ-036 Reset pulse during BUSY -> all outputs zero asynchronously, no ready pulse, subsequent m0 read completes normally with m0 priority.
REQ-037 Spurious s_ready in IDLE with no requests -> no ready, grant stays 00.
